// File: rtl/alu_imm_pipeline.sv
// ALU reg-imm execution pipeline: operand collect, RV32I OP-IMM execute, writeback hold.
// Operand A comes from x0, PRF read, writeback-bus forward or fast-forward pipes.

package core_types_pkg;
   localparam int unsigned LOG_PR_COUNT       = 7;
   localparam int unsigned LOG_ROB_ENTRIES    = 6;
   localparam int unsigned PRF_BANK_COUNT     = 4;
   localparam int unsigned LOG_PRF_BANK_COUNT = 2;

   typedef struct packed {
      logic [3:0]                 op;
      logic [11:0]                imm12;
      logic [LOG_PR_COUNT-1:0]    dest_pr;
      logic [LOG_ROB_ENTRIES-1:0] rob_index;
   } alu_imm_payload_t;
endpackage

module alu_imm_pipeline
   import core_types_pkg::*;
#(
   parameter int unsigned FAST_FORWARD_PIPE_COUNT     = 4,
   parameter int unsigned LOG_FAST_FORWARD_PIPE_COUNT = $clog2(FAST_FORWARD_PIPE_COUNT)
) (
   input  logic                                     CLK,
   input  logic                                     RST,
   input  logic                                     issue_valid,
   input  logic [3:0]                               issue_op,
   input  logic [11:0]                              issue_imm12,
   input  logic                                     issue_A_is_reg,
   input  logic                                     issue_A_is_bus_forward,
   input  logic                                     issue_A_is_fast_forward,
   input  logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0]   issue_A_fast_forward_pipe,
   input  logic [LOG_PRF_BANK_COUNT-1:0]            issue_A_bank,
   input  logic [LOG_PR_COUNT-1:0]                  issue_dest_PR,
   input  logic [LOG_ROB_ENTRIES-1:0]               issue_ROB_index,
   output logic                                     issue_ready,
   input  logic                                     A_reg_read_ack,
   input  logic [31:0]                              A_reg_read_data,
   input  logic [PRF_BANK_COUNT-1:0][31:0]          WB_bus_data_by_bank,
   input  logic [FAST_FORWARD_PIPE_COUNT-1:0][31:0] fast_forward_data_by_pipe,
   output logic                                     WB_valid,
   output logic [31:0]                              WB_data,
   output logic [LOG_PR_COUNT-1:0]                  WB_PR,
   output logic [LOG_ROB_ENTRIES-1:0]               WB_ROB_index,
   input  logic                                     WB_ready
);

   localparam int unsigned XLEN = 32;

   // OC stage
   logic                                   oc_valid;
   logic                                   oc_first;
   logic                                   oc_have;
   logic                                   oc_is_reg;
   logic                                   oc_is_ff;
   logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] oc_pipe;
   logic [XLEN-1:0]                        oc_operand;
   alu_imm_payload_t                       oc_pl;

   // EX stage
   logic                                   ex_valid;
   logic [XLEN-1:0]                        ex_a;
   alu_imm_payload_t                       ex_pl;

   logic            capture_c;
   logic            oc_resolved_c;
   logic            oc_advance_c;
   logic            ex_advance_c;
   logic            issue_fire_c;
   logic [XLEN-1:0] oc_a_c;
   logic [XLEN-1:0] imm_sext_c;
   logic [4:0]      shamt_c;
   logic [XLEN-1:0] ex_result_c;

   // Operand resolution and stage handshakes; fast-forward is only visible in the first OC cycle
   always_comb begin
      capture_c     = (oc_first & oc_is_ff) | (oc_is_reg & A_reg_read_ack);
      oc_resolved_c = oc_have | capture_c;
      oc_a_c        = oc_operand;
      if (!oc_have) begin
         oc_a_c = oc_is_ff ? fast_forward_data_by_pipe[oc_pipe] : A_reg_read_data;
      end
      ex_advance_c  = ex_valid & (~WB_valid | WB_ready);
      oc_advance_c  = oc_valid & oc_resolved_c & (~ex_valid | ex_advance_c);
      issue_ready   = ~RST & (~oc_valid | oc_advance_c);
      issue_fire_c  = issue_valid & issue_ready;
   end

   // OP-IMM function on the EX registers
   always_comb begin
      imm_sext_c  = {{(XLEN-12){ex_pl.imm12[11]}}, ex_pl.imm12};
      shamt_c     = ex_pl.imm12[4:0];
      ex_result_c = '0;
      case (ex_pl.op[2:0])
         3'b000: ex_result_c = ex_a + imm_sext_c;
         3'b001: ex_result_c = ex_a << shamt_c;
         3'b010: ex_result_c = {31'b0, ($signed(ex_a) < $signed(imm_sext_c))};
         3'b011: ex_result_c = {31'b0, (ex_a < imm_sext_c)};
         3'b100: ex_result_c = ex_a ^ imm_sext_c;
         3'b101: ex_result_c = ex_pl.op[3] ? XLEN'($signed(ex_a) >>> shamt_c) : (ex_a >> shamt_c);
         3'b110: ex_result_c = ex_a | imm_sext_c;
         3'b111: ex_result_c = ex_a & imm_sext_c;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         oc_valid     <= 1'b0;
         oc_first     <= 1'b0;
         oc_have      <= 1'b0;
         ex_valid     <= 1'b0;
         WB_valid     <= 1'b0;
         WB_data      <= '0;
         WB_PR        <= '0;
         WB_ROB_index <= '0;
      end else begin
         // Bus forward and x0 resolve at issue; reg and fast-forward resolve in OC
         if (issue_fire_c) begin
            oc_valid   <= 1'b1;
            oc_first   <= 1'b1;
            oc_pl      <= '{op: issue_op, imm12: issue_imm12,
                            dest_pr: issue_dest_PR, rob_index: issue_ROB_index};
            oc_is_reg  <= issue_A_is_reg & ~issue_A_is_bus_forward;
            oc_is_ff   <= issue_A_is_fast_forward & ~issue_A_is_reg & ~issue_A_is_bus_forward;
            oc_pipe    <= issue_A_fast_forward_pipe;
            oc_have    <= issue_A_is_bus_forward | (~issue_A_is_reg & ~issue_A_is_fast_forward);
            oc_operand <= issue_A_is_bus_forward ? WB_bus_data_by_bank[issue_A_bank] : '0;
         end else begin
            oc_first <= 1'b0;
            if (oc_advance_c) begin
               oc_valid <= 1'b0;
            end else if (oc_valid && !oc_have && capture_c) begin
               oc_have    <= 1'b1;
               oc_operand <= oc_a_c;
            end
         end

         if (oc_advance_c) begin
            ex_valid <= 1'b1;
            ex_pl    <= oc_pl;
            ex_a     <= oc_a_c;
         end else if (ex_advance_c) begin
            ex_valid <= 1'b0;
         end

         if (ex_advance_c) begin
            WB_valid     <= 1'b1;
            WB_data      <= ex_result_c;
            WB_PR        <= ex_pl.dest_pr;
            WB_ROB_index <= ex_pl.rob_index;
         end else if (WB_ready) begin
            WB_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_imm_pipeline.sv
// Directed bench for alu_imm_pipeline with an arithmetic reference model and writeback scoreboard.

module tb_alu_imm_pipeline;
   import core_types_pkg::*;

   localparam int unsigned FFN = 4;
   localparam int unsigned LFF = 2;

   logic                              CLK = 1'b0;
   logic                              RST = 1'b1;
   logic                              issue_valid = 1'b0;
   logic [3:0]                        issue_op = '0;
   logic [11:0]                       issue_imm12 = '0;
   logic                              issue_A_is_reg = 1'b0;
   logic                              issue_A_is_bus_forward = 1'b0;
   logic                              issue_A_is_fast_forward = 1'b0;
   logic [LFF-1:0]                    issue_A_fast_forward_pipe = '0;
   logic [LOG_PRF_BANK_COUNT-1:0]     issue_A_bank = '0;
   logic [LOG_PR_COUNT-1:0]           issue_dest_PR = '0;
   logic [LOG_ROB_ENTRIES-1:0]        issue_ROB_index = '0;
   logic                              issue_ready;
   logic                              A_reg_read_ack = 1'b0;
   logic [31:0]                       A_reg_read_data = '0;
   logic [PRF_BANK_COUNT-1:0][31:0]   WB_bus_data_by_bank = '0;
   logic [FFN-1:0][31:0]              fast_forward_data_by_pipe = '0;
   logic                              WB_valid;
   logic [31:0]                       WB_data;
   logic [LOG_PR_COUNT-1:0]           WB_PR;
   logic [LOG_ROB_ENTRIES-1:0]        WB_ROB_index;
   logic                              WB_ready = 1'b1;

   alu_imm_pipeline #(.FAST_FORWARD_PIPE_COUNT(FFN), .LOG_FAST_FORWARD_PIPE_COUNT(LFF)) dut (
      .CLK(CLK), .RST(RST),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_imm12(issue_imm12),
      .issue_A_is_reg(issue_A_is_reg), .issue_A_is_bus_forward(issue_A_is_bus_forward),
      .issue_A_is_fast_forward(issue_A_is_fast_forward),
      .issue_A_fast_forward_pipe(issue_A_fast_forward_pipe), .issue_A_bank(issue_A_bank),
      .issue_dest_PR(issue_dest_PR), .issue_ROB_index(issue_ROB_index), .issue_ready(issue_ready),
      .A_reg_read_ack(A_reg_read_ack), .A_reg_read_data(A_reg_read_data),
      .WB_bus_data_by_bank(WB_bus_data_by_bank), .fast_forward_data_by_pipe(fast_forward_data_by_pipe),
      .WB_valid(WB_valid), .WB_data(WB_data), .WB_PR(WB_PR), .WB_ROB_index(WB_ROB_index),
      .WB_ready(WB_ready)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0]                data;
      logic [LOG_PR_COUNT-1:0]    pr;
      logic [LOG_ROB_ENTRIES-1:0] rob;
   } exp_t;

   exp_t exp_q[$];
   int   wb_cycles[$];
   int   cmp_total = 0;
   int   cmp_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      cmp_total++;
      if (act !== req) begin
         cmp_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: OP-IMM semantics in plain 64-bit integer arithmetic
   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [11:0] imm12);
      longint          sa, si, p2, q;
      longint unsigned ua, ui, r;
      ua = longint'(a);
      sa = a[31] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
      si = imm12[11] ? longint'(imm12) - 64'sd4096 : longint'(imm12);
      ui = longint'(si) & 64'hFFFF_FFFF;
      p2 = 64'sd1 << int'(imm12[4:0]);
      r  = 0;
      case (op[2:0])
         3'd0: r = ua + ui;
         3'd1: r = ua * longint'(p2);
         3'd2: r = (sa < si) ? 64'd1 : 64'd0;
         3'd3: r = (ua < ui) ? 64'd1 : 64'd0;
         3'd4: r = ua ^ ui;
         3'd5: begin
            if (op[3] && sa < 0) q = -((-sa + p2 - 1) / p2);
            else                 q = longint'(ua) / p2;
            r = longint'(q);
         end
         3'd6: r = ua | ui;
         3'd7: r = ua & ui;
      endcase
      return r[31:0];
   endfunction

   // Scoreboard: every writeback handshake must match the oldest accepted op; stalls must hold outputs
   exp_t                       e_cur;
   bit                         hold = 0;
   logic [31:0]                hd;
   logic [LOG_PR_COUNT-1:0]    hp;
   logic [LOG_ROB_ENTRIES-1:0] hr;
   always @(negedge CLK) begin
      if (RST) begin
         hold = 0;
      end else begin
         if (hold) begin
            check("wb_hold_valid", 32'(WB_valid), 32'd1);
            check("wb_hold_data", WB_data, hd);
            check("wb_hold_pr", 32'(WB_PR), 32'(hp));
            check("wb_hold_rob", 32'(WB_ROB_index), 32'(hr));
         end
         if (WB_valid === 1'b1 && WB_ready) begin
            wb_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
               cmp_total++;
               cmp_fail++;
               $display("FAIL wb_spurious: got writeback %h, required none", WB_data);
            end else begin
               e_cur = exp_q.pop_front();
               check("wb_data", WB_data, e_cur.data);
               check("wb_pr", 32'(WB_PR), 32'(e_cur.pr));
               check("wb_rob", 32'(WB_ROB_index), 32'(e_cur.rob));
            end
         end
         hold = (WB_valid === 1'b1) && !WB_ready;
         hd   = WB_data;
         hp   = WB_PR;
         hr   = WB_ROB_index;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // src: 0 x0, 1 PRF read, 2 bus forward, 3 fast forward. Returns one cycle after handshake.
   task automatic issue(input logic [3:0] op, input logic [11:0] imm, input int src,
                        input logic [31:0] a, input int sel, input int pr, input int rob,
                        input int budget, output bit ok, output int icyc);
      issue_op                  = op;
      issue_imm12               = imm;
      issue_A_is_reg            = (src == 1);
      issue_A_is_bus_forward    = (src == 2);
      issue_A_is_fast_forward   = (src == 3);
      issue_A_fast_forward_pipe = LFF'(sel);
      issue_A_bank              = LOG_PRF_BANK_COUNT'(sel);
      issue_dest_PR             = LOG_PR_COUNT'(pr);
      issue_ROB_index           = LOG_ROB_ENTRIES'(rob);
      if (src == 2) WB_bus_data_by_bank[sel] = a;
      issue_valid = 1'b1;
      ok   = 0;
      icyc = -1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge CLK);
         if (issue_ready === 1'b1) begin
            ok   = 1;
            icyc = cyc;
            exp_q.push_back('{alu_model(op, a, imm), LOG_PR_COUNT'(pr), LOG_ROB_ENTRIES'(rob)});
         end
         step();
      end
      issue_valid             = 1'b0;
      issue_A_is_reg          = 1'b0;
      issue_A_is_bus_forward  = 1'b0;
      issue_A_is_fast_forward = 1'b0;
      if (ok && src == 3) fast_forward_data_by_pipe[sel] = a;
   endtask

   task automatic wait_wb(input string name, output int c);
      bit seen = 0;
      c = -1;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge CLK);
         if (WB_valid === 1'b1) begin
            seen = 1;
            c    = cyc;
         end
      end
      if (!seen) begin
         cmp_total++;
         cmp_fail++;
         $display("FAIL %s: got no WB_valid within 30 cycles, required one", name);
      end
   endtask

   initial begin
      bit ok;
      int ic, wc, acc, base;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_issue_ready", 32'(issue_ready), 32'd0);
      check("rst_wb_valid", 32'(WB_valid), 32'd0);
      check("rst_wb_data", WB_data, 32'd0);
      check("rst_wb_pr", 32'(WB_PR), 32'd0);
      check("rst_wb_rob", 32'(WB_ROB_index), 32'd0);
      step();
      RST = 1'b0;
      @(negedge CLK);
      check("post_rst_issue_ready", 32'(issue_ready), 32'd1);

      check("model_addi_neg1", alu_model(4'b0000, 32'h0, 12'hFFF), 32'hFFFF_FFFF);
      check("model_srai", alu_model(4'b1101, 32'h8000_0000, 12'h004), 32'hF800_0000);
      check("model_srli", alu_model(4'b0101, 32'h8000_0000, 12'h004), 32'h0800_0000);
      check("model_slti", alu_model(4'b0010, 32'hFFFF_FFFE, 12'h001), 32'd1);
      check("model_sltiu", alu_model(4'b0011, 32'hFFFF_FFFE, 12'h001), 32'd0);
      check("model_slli", alu_model(4'b0001, 32'h0000_0003, 12'h41F), 32'h8000_0000);
      step();

      // ADDI x0, -1
      issue(4'b0000, 12'hFFF, 0, 32'h0, 0, 5, 9, 4, ok, ic);
      check("addi_accept", 32'(ok), 32'd1);
      wait_wb("addi_wb", wc);
      check("addi_latency", 32'(wc), 32'(ic + 3));
      check("addi_data", WB_data, 32'hFFFF_FFFF);
      step();

      // SRAI / SRLI from bus forward bank 1
      issue(4'b1101, 12'h004, 2, 32'h8000_0000, 1, 6, 10, 4, ok, ic);
      wait_wb("srai_wb", wc);
      check("srai_latency", 32'(wc), 32'(ic + 3));
      check("srai_data", WB_data, 32'hF800_0000);
      step();
      issue(4'b0101, 12'h004, 2, 32'h8000_0000, 1, 7, 11, 4, ok, ic);
      wait_wb("srli_wb", wc);
      check("srli_data", WB_data, 32'h0800_0000);
      step();

      // SLTI with PRF ack arriving 3 cycles after OC entry
      A_reg_read_ack = 1'b0;
      issue(4'b0010, 12'h001, 1, 32'hFFFF_FFFE, 0, 8, 12, 4, ok, ic);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("slti_stall_issue_ready", 32'(issue_ready), 32'd0);
         step();
      end
      A_reg_read_ack  = 1'b1;
      A_reg_read_data = 32'hFFFF_FFFE;
      @(negedge CLK);
      check("slti_ack_issue_ready", 32'(issue_ready), 32'd1);
      step();
      A_reg_read_ack  = 1'b0;
      A_reg_read_data = 32'h0000_0000;
      wait_wb("slti_wb", wc);
      check("slti_latency", 32'(wc), 32'(ic + 6));
      check("slti_data", WB_data, 32'd1);
      step();

      // SLTIU, ack in the first OC cycle
      A_reg_read_ack  = 1'b1;
      A_reg_read_data = 32'hFFFF_FFFE;
      issue(4'b0011, 12'h001, 1, 32'hFFFF_FFFE, 0, 9, 13, 4, ok, ic);
      wait_wb("sltiu_wb", wc);
      check("sltiu_latency", 32'(wc), 32'(ic + 3));
      check("sltiu_data", WB_data, 32'd0);
      A_reg_read_ack  = 1'b0;
      A_reg_read_data = 32'h0;
      step();

      // ANDI from fast-forward pipe 2 under writeback backpressure
      WB_ready = 1'b0;
      issue(4'b0111, 12'h0FF, 3, 32'h1234_5678, 2, 10, 14, 4, ok, ic);
      step();
      fast_forward_data_by_pipe = {4{32'hDEAD_BEEF}};
      wait_wb("andi_wb", wc);
      check("andi_latency", 32'(wc), 32'(ic + 3));
      check("andi_data", WB_data, 32'h0000_0078);
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge CLK);
         check("andi_stall_data", WB_data, 32'h0000_0078);
      end
      step();
      WB_ready = 1'b1;
      step();

      // Six ADDIs under full backpressure: only three fit
      WB_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         issue(4'b1000, 12'(i + 1), 0, 32'h0, 0, 20 + i, 30 + i, 5, ok, ic);
         if (ok) acc++;
      end
      check("bp_accepted", 32'(acc), 32'd3);
      @(negedge CLK);
      check("bp_issue_ready", 32'(issue_ready), 32'd0);
      step();
      base = wb_cycles.size();
      WB_ready = 1'b1;
      for (int i = 3; i < 6; i++) begin
         issue(4'b1000, 12'(i + 1), 0, 32'h0, 0, 20 + i, 30 + i, 5, ok, ic);
         check("bp_reissue_accept", 32'(ok), 32'd1);
      end
      for (int i = 0; i < 20 && wb_cycles.size() < base + 6; i++) @(negedge CLK);
      check("bp_wb_count", 32'(wb_cycles.size() - base), 32'd6);
      if (wb_cycles.size() >= base + 6)
         check("bp_wb_back_to_back", 32'(wb_cycles[base + 5] - wb_cycles[base]), 32'd5);
      step();

      // Reset with three ops in flight
      WB_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(4'b0110, 12'h0F0, 0, 32'h0, 0, 40 + i, 50 + i, 5, ok, ic);
      @(negedge CLK);
      check("flight_wb_valid", 32'(WB_valid), 32'd1);
      step();
      RST = 1'b1;
      exp_q.delete();
      @(negedge CLK);
      check("mid_rst_issue_ready", 32'(issue_ready), 32'd0);
      step();
      @(negedge CLK);
      check("mid_rst_wb_valid", 32'(WB_valid), 32'd0);
      check("mid_rst_wb_data", WB_data, 32'd0);
      check("mid_rst_wb_pr", 32'(WB_PR), 32'd0);
      check("mid_rst_wb_rob", 32'(WB_ROB_index), 32'd0);
      check("mid_rst_issue_ready2", 32'(issue_ready), 32'd0);
      step();
      RST      = 1'b0;
      WB_ready = 1'b1;
      issue(4'b0000, 12'h123, 0, 32'h0, 0, 60, 61, 4, ok, ic);
      check("post_rst_accept", 32'(ok), 32'd1);
      wait_wb("post_rst_wb", wc);
      check("post_rst_latency", 32'(wc), 32'(ic + 3));
      check("post_rst_data", WB_data, 32'h0000_0123);
      repeat (4) step();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_fail);
      $finish;
   end

endmodule
